// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states and PC arithmetic constants.
package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_ERR
  } fetch_state_e;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam int          JUMP_IDX_W = 26;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, PC-relative branch or J-type jump (jump has priority).
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0]           pc,
  input  logic [31:0]           signimm,
  input  logic [JUMP_IDX_W-1:0] jump_idx,
  input  logic                  branch_taken,
  input  logic                  jump,
  output logic [31:0]           next_pc,
  output logic [31:0]           pc_plus4
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] selected;

  always_comb begin
    pc_plus4      = pc + PC_STEP;
    // Modulo-2^32 add: a branch may wrap around the address space.
    branch_target = pc_plus4 + (signimm << 2);
    jump_target   = {pc_plus4[31:28], jump_idx, 2'b00};
    if (jump) begin
      selected = jump_target;
    end else if (branch_taken) begin
      selected = branch_target;
    end else begin
      selected = pc_plus4;
    end
    next_pc = {selected[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch FSM with ready-based imem handshake, stall hold and timeout.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic [31:0] signimm,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_error
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      PC_RESET = RESET_VECTOR & ~32'd3;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      next_pc;

  pc_next_sel u_pc_next_sel (
    .pc           (pc_q),
    .signimm      (signimm),
    .jump_idx     (instr[JUMP_IDX_W-1:0]),
    .branch_taken (branch_taken),
    .jump         (jump),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4)
  );

  // Output decode kept separate from next-state logic so next_pc (which depends on instr)
  // does not feed back into the block that produces instr.
  always_comb begin
    imem_req    = 1'b0;
    instr       = instr_q;
    instr_valid = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req    = 1'b1;
        instr       = imem_rdata;
        instr_valid = imem_ready;
      end
      S_HOLD: instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          cnt_d = '0;
          if (stall) begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end else begin
            pc_d = next_pc;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERR: ;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed literal checks plus randomized traffic vs a model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] signimm;
  logic        branch_taken;
  logic        jump;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_error;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .signimm      (signimm),
    .branch_taken (branch_taken),
    .jump         (jump),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_error  (fetch_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase the unit is in, expressed as plain flags.
  bit          m_live = 0;
  bit          m_booted, m_holding, m_err;
  logic [31:0] m_pc, m_held;
  int          m_miss;

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] ins,
                                         input logic [31:0] imm, input bit br, input bit jp);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jp) return {seq[31:28], ins[25:0], 2'b00};
    if (br) return seq + imm * 32'd4;
    return seq;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_booted = 0; m_holding = 0; m_err = 0; m_miss = 0;
      m_pc = RV & ~32'd3;
    end else if (m_live) begin
      if (!m_booted) m_booted = 1;
      else if (m_err) ;
      else if (m_holding) begin
        if (!stall) begin
          m_pc = target(m_pc, m_held, signimm, branch_taken, jump);
          m_holding = 0;
        end
      end else if (imem_ready) begin
        m_miss = 0;
        if (stall) begin
          m_held = imem_rdata;
          m_holding = 1;
        end else begin
          m_pc = target(m_pc, imem_rdata, signimm, branch_taken, jump);
        end
      end else begin
        m_miss++;
        if (m_miss == TO) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_req, exp_valid;
    if (m_live) begin
      exp_req   = m_booted && !m_holding && !m_err;
      exp_valid = m_holding || (exp_req && imem_ready);
      chk("imem_req", imem_req, exp_req);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr_valid", instr_valid, exp_valid);
      chk("fetch_error", fetch_error, m_err);
      if (exp_valid) chk("instr", instr, m_holding ? m_held : imem_rdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; imem_ready = 0; stall = 0; branch_taken = 0; jump = 0;
    signimm = 0; imem_rdata = 0;
    tick; tick;
    @(negedge clk);
    chk("rst_pc", pc, RV);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_error, 0);
    tick;
    reset = 0; imem_ready = 1;
    tick;  // S_BOOT -> fetching

    // Sequential fetch 0,4,8,C; at C jump to 0x100.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin jump = 1; imem_rdata = 32'h0800_0040; end
      else imem_rdata = $urandom & 32'h03FF_FFFF;
      @(negedge clk);
      chk("seq_addr", imem_addr, 32'(k * 4));
      chk("seq_valid", instr_valid, 1);
      tick;
    end

    jump = 0; branch_taken = 1; signimm = 32'hFFFF_FFFE;
    @(negedge clk); chk("at_100", imem_addr, 32'h100); tick;
    signimm = 32'h0;
    @(negedge clk); chk("br_back", imem_addr, 32'hFC); tick;
    signimm = 32'h10;
    @(negedge clk); chk("at_100b", imem_addr, 32'h100); tick;
    signimm = (32'h3000_0010 - 32'h148) >> 2;
    @(negedge clk); chk("br_fwd", imem_addr, 32'h144); tick;
    jump = 1; imem_rdata = 32'h0000_0040; signimm = 32'd5;
    @(negedge clk); chk("at_3000", imem_addr, 32'h3000_0010); tick;

    // Stall over a valid fetch: word held for three stalled cycles.
    jump = 0; branch_taken = 0; stall = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("jmp_wins", imem_addr, 32'h3000_0100); tick;
    for (int h = 0; h < 3; h++) begin
      if (h == 2) stall = 0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_instr", instr, 32'hDEAD_BEEF);
      chk("hold_pc", pc, 32'h3000_0100);
      chk("hold_req", imem_req, 0);
      tick;
    end
    branch_taken = 1; signimm = (32'hFFFF_FFFC - 32'h3000_0108) >> 2;
    @(negedge clk); chk("stall_adv", pc, 32'h3000_0104); tick;
    branch_taken = 0;
    @(negedge clk); chk("at_top", pc, 32'hFFFF_FFFC); tick;
    imem_ready = 0;
    @(negedge clk); chk("pc_wrap", pc, 32'h0); chk("wrap_err", fetch_error, 0);

    // Timeout: error exactly on the TO-th missing cycle.
    for (int t = 1; t <= TO; t++) begin
      tick;
      @(negedge clk);
      if (t == TO - 1) chk("to_early", fetch_error, 0);
    end
    chk("to_err", fetch_error, 1);
    chk("to_req", imem_req, 0);
    tick;
    reset = 1;
    tick;
    @(negedge clk);
    chk("to_rst_err", fetch_error, 0);
    chk("to_rst_pc", pc, RV);
    tick;

    // Reset while holding.
    reset = 0; imem_ready = 1;
    tick;
    tick;
    stall = 1;
    tick;
    @(negedge clk);
    chk("hold2_req", imem_req, 0);
    chk("hold2_pc", pc, 32'h4);
    tick;
    reset = 1;
    tick;
    @(negedge clk);
    chk("hrst_pc", pc, RV);
    chk("hrst_valid", instr_valid, 0);
    tick;
    reset = 0; stall = 0;

    // Randomized traffic, with periodic starved-imem windows to provoke timeouts.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 149) == 0);
      imem_ready   = (((i / 200) % 5) == 4) ? ($urandom_range(0, 9) == 0)
                                            : ($urandom_range(0, 4) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      signimm      = 32'($signed($urandom_range(0, 255)) - 128);
      imem_rdata   = $urandom;
      tick;
    end
    reset = 1;
    tick;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
